fft_xk_frame_capture: RTL and testbench

- Receive-side endpoint for the FFT core output stream (xk AXI4-Stream: tvalid/tdata/tlast/tuser).
- Captures one complete output frame into an internal buffer of 2^LOGS_FFT_LEN complex words, latches the frame block exponent and checks frame integrity.
- Provides a random-access read port so downstream logic (spectrum display, host readout) can fetch the captured bins.
- Sits directly on the FFT core's o_axi4s_data_* outputs, in parallel with or in place of the frame checker.

---
 rtl/fft_xk_frame_capture_if.sv | 19 +
 rtl/fft_xk_frame_capture.sv | 157 +++++++++++++++
 tb/tb_fft_xk_frame_capture.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_xk_frame_capture_if.sv
// FFT xk output stream bundle (AXI4-Stream without tready).
// The source drives through master, the capture endpoint listens through slave.
`timescale 1ns/1ps
`default_nettype none

interface fft_xk_frame_capture_if #(
   parameter int DATAOUT_WIDTH = 16,
   parameter int USER_WIDTH    = 24
);
   logic                       tvalid;
   logic [2*DATAOUT_WIDTH-1:0] tdata;
   logic                       tlast;
   logic [USER_WIDTH-1:0]      tuser;

   modport master (output tvalid, tdata, tlast, tuser);
   modport slave  (input  tvalid, tdata, tlast, tuser);
endinterface

`default_nettype wire

// File: rtl/fft_xk_frame_capture.sv
// Captures one whole FFT output frame into a bin buffer, latches its block exponent,
// checks length/index integrity and serves the bins through a registered read port.
`timescale 1ns/1ps
`default_nettype none

module fft_xk_frame_capture #(
   parameter int LOGS_FFT_LEN  = 13,
   parameter int OUTPUT_WIDTH  = 11,
   parameter int DATAOUT_WIDTH = 16,
   parameter int USER_WIDTH    = 24
) (
   input  logic                      i_clk,
   input  logic                      srstn,
   input  logic                      i_aclken,
   fft_xk_frame_capture_if.slave     xk,
   input  logic                      i_arm,
   input  logic                      i_rd_en,
   input  logic [LOGS_FFT_LEN-1:0]   i_rd_addr,
   output logic [2*OUTPUT_WIDTH-1:0] o_rd_data,
   output logic                      o_rd_valid,
   output logic [7:0]                o_blk_exp,
   output logic                      o_frame_ready,
   output logic                      o_busy,
   output logic                      o_err_len,
   output logic                      o_err_idx,
   output logic [15:0]               o_frame_cnt
);

   localparam int                    DEPTH     = 1 << LOGS_FFT_LEN;
   localparam logic [LOGS_FFT_LEN-1:0] LAST_ADDR = LOGS_FFT_LEN'(DEPTH - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t                    state;
   logic                      sof;
   logic [LOGS_FFT_LEN-1:0]   cnt;
   logic [2*OUTPUT_WIDTH-1:0] mem [DEPTH];

   logic                      beat;
   logic [OUTPUT_WIDTH-1:0]   re;
   logic [OUTPUT_WIDTH-1:0]   im;
   logic [LOGS_FFT_LEN-1:0]   idx;
   logic [7:0]                exp_in;
   logic                      wr_en;
   logic [LOGS_FFT_LEN-1:0]   wr_addr;
   logic                      unused_bits;

   assign beat    = i_aclken & xk.tvalid;
   assign re      = xk.tdata[OUTPUT_WIDTH-1:0];
   assign im      = xk.tdata[DATAOUT_WIDTH +: OUTPUT_WIDTH];
   assign idx     = xk.tuser[LOGS_FFT_LEN-1:0];
   assign exp_in  = xk.tuser[USER_WIDTH-1 -: 8];
   // Lane padding and the middle of tuser carry nothing this block needs.
   assign unused_bits = ^{xk.tdata, xk.tuser};

   // The first beat of a frame is only written when it arrives on a frame boundary.
   assign wr_en   = beat && (((state == ARMED) && sof) || (state == CAPTURE));
   assign wr_addr = (state == CAPTURE) ? cnt : '0;

   always_ff @(posedge i_clk) begin
      if (wr_en) begin
         mem[wr_addr] <= {im, re};
      end
   end

   always_ff @(posedge i_clk or negedge srstn) begin
      if (!srstn) begin
         o_rd_data  <= '0;
         o_rd_valid <= 1'b0;
      end else if (i_aclken) begin
         o_rd_valid <= i_rd_en;
         if (i_rd_en) begin
            o_rd_data <= mem[i_rd_addr];
         end
      end
   end

   always_ff @(posedge i_clk or negedge srstn) begin
      if (!srstn) begin
         state         <= IDLE;
         sof           <= 1'b1;
         cnt           <= '0;
         o_blk_exp     <= '0;
         o_frame_ready <= 1'b0;
         o_busy        <= 1'b0;
         o_err_len     <= 1'b0;
         o_err_idx     <= 1'b0;
         o_frame_cnt   <= '0;
      end else if (i_aclken) begin
         if (beat) begin
            sof <= xk.tlast;
         end
         case (state)
            IDLE: begin
               if (i_arm) begin
                  state  <= ARMED;
                  o_busy <= 1'b1;
               end
            end
            ARMED: begin
               if (beat && sof) begin
                  o_blk_exp <= exp_in;
                  cnt       <= LOGS_FFT_LEN'(1);
                  if (xk.tlast) begin
                     state         <= DONE;
                     o_busy        <= 1'b0;
                     o_frame_ready <= 1'b1;
                     o_frame_cnt   <= o_frame_cnt + 16'd1;
                     o_err_len     <= (LAST_ADDR != '0);
                  end else begin
                     state <= CAPTURE;
                  end
               end
            end
            CAPTURE: begin
               if (beat) begin
                  cnt <= cnt + LOGS_FFT_LEN'(1);
                  if (idx != cnt) begin
                     o_err_idx <= 1'b1;
                  end
                  // Frame ends on tlast or on a full buffer, whichever comes first.
                  if (xk.tlast || (cnt == LAST_ADDR)) begin
                     state         <= DONE;
                     o_busy        <= 1'b0;
                     o_frame_ready <= 1'b1;
                     o_frame_cnt   <= o_frame_cnt + 16'd1;
                     if (!(xk.tlast && (cnt == LAST_ADDR))) begin
                        o_err_len <= 1'b1;
                     end
                  end
               end
            end
            DONE: begin
               if (i_arm) begin
                  state         <= ARMED;
                  o_busy        <= 1'b1;
                  o_frame_ready <= 1'b0;
                  o_err_len     <= 1'b0;
                  o_err_idx     <= 1'b0;
               end
            end
            default: begin
               state  <= IDLE;
               o_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fft_xk_frame_capture.sv
// Randomized bench for fft_xk_frame_capture (N=16) against a frame-level reference model.
`timescale 1ns/1ps
`default_nettype none

module tb_fft_xk_frame_capture;

   localparam int LOGS = 4;
   localparam int N    = 16;
   localparam int OW   = 11;
   localparam int DW   = 16;
   localparam int UW   = 24;

   logic            clk = 1'b0;
   logic            srstn;
   logic            aclken;
   logic            arm;
   logic            rd_en;
   logic [LOGS-1:0] rd_addr;
   logic [2*OW-1:0] rd_data;
   logic            rd_valid;
   logic [7:0]      blk_exp;
   logic            frame_ready;
   logic            busy;
   logic            err_len;
   logic            err_idx;
   logic [15:0]     frame_cnt;

   always #5 clk = ~clk;

   fft_xk_frame_capture_if #(.DATAOUT_WIDTH(DW), .USER_WIDTH(UW)) xk_bus ();

   fft_xk_frame_capture #(
      .LOGS_FFT_LEN (LOGS),
      .OUTPUT_WIDTH (OW),
      .DATAOUT_WIDTH(DW),
      .USER_WIDTH   (UW)
   ) dut (
      .i_clk        (clk),
      .srstn        (srstn),
      .i_aclken     (aclken),
      .xk           (xk_bus),
      .i_arm        (arm),
      .i_rd_en      (rd_en),
      .i_rd_addr    (rd_addr),
      .o_rd_data    (rd_data),
      .o_rd_valid   (rd_valid),
      .o_blk_exp    (blk_exp),
      .o_frame_ready(frame_ready),
      .o_busy       (busy),
      .o_err_len    (err_len),
      .o_err_idx    (err_idx),
      .o_frame_cnt  (frame_cnt)
   );

   typedef struct {
      logic [OW-1:0]   re;
      logic [OW-1:0]   im;
      logic [LOGS-1:0] idx;
      logic [7:0]      bexp;
      bit              last;
      bit              sof;
   } beat_t;

   // Beats accepted since the last arm, each tagged with whether it opened a frame.
   beat_t           sent_q[$];
   bit              prev_last;
   int              n_checks;
   int              n_pass;
   int              exp_cnt;

   logic [OW-1:0]   f_re   [32];
   logic [OW-1:0]   f_im   [32];
   logic [LOGS-1:0] f_idx  [32];
   logic [7:0]      f_exp  [32];
   bit              f_last [32];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, want);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Random idle cycles and beats hidden by a low clock enable.
   task automatic idle_gap();
      repeat ($urandom_range(0, 2)) begin
         if ($urandom_range(0, 1) == 1) begin
            aclken        = 1'b1;
            xk_bus.tvalid = 1'b0;
         end else begin
            aclken        = 1'b0;
            xk_bus.tvalid = 1'b1;
            xk_bus.tdata  = $urandom;
            xk_bus.tlast  = 1'($urandom_range(0, 1));
            xk_bus.tuser  = 24'($urandom);
         end
         tick();
      end
      aclken        = 1'b1;
      xk_bus.tvalid = 1'b0;
   endtask

   task automatic send_beat(input int k);
      beat_t b;
      idle_gap();
      xk_bus.tdata  = {5'($urandom), f_im[k], 5'($urandom), f_re[k]};
      xk_bus.tuser  = {f_exp[k], 12'($urandom), f_idx[k]};
      xk_bus.tlast  = f_last[k];
      xk_bus.tvalid = 1'b1;
      aclken        = 1'b1;
      tick();
      xk_bus.tvalid = 1'b0;
      b.re   = f_re[k];
      b.im   = f_im[k];
      b.idx  = f_idx[k];
      b.bexp = f_exp[k];
      b.last = f_last[k];
      b.sof  = prev_last;
      sent_q.push_back(b);
      prev_last = f_last[k];
   endtask

   task automatic send_range(input int lo, input int hi);
      for (int k = lo; k <= hi; k++) send_beat(k);
   endtask

   task automatic make_frame(input int nbeats, input int last_pos);
      for (int k = 0; k < nbeats; k++) begin
         f_re[k]   = OW'($urandom);
         f_im[k]   = OW'($urandom);
         f_idx[k]  = LOGS'(k);
         f_exp[k]  = 8'($urandom);
         f_last[k] = (k == last_pos);
      end
   endtask

   task automatic pulse_arm();
      aclken        = 1'b1;
      xk_bus.tvalid = 1'b0;
      arm           = 1'b1;
      tick();
      arm           = 1'b0;
   endtask

   task automatic do_arm();
      pulse_arm();
      sent_q.delete();
   endtask

   task automatic read_check(input int addr, input logic [2*OW-1:0] want, input string tag);
      rd_en   = 1'b1;
      rd_addr = LOGS'(addr);
      tick();
      rd_en   = 1'b0;
      check({tag, "_valid"}, 32'(rd_valid), 32'd1);
      check(tag, 32'(rd_data), 32'(want));
   endtask

   // Reference: the capture starts at the first beat that opened a frame and ends at
   // tlast or after N beats; indices must count up from the capture start.
   task automatic check_capture(input string tag);
      int start;
      int len;
      bit done;
      bit errl;
      bit erri;
      start = -1;
      len   = 0;
      done  = 0;
      errl  = 0;
      erri  = 0;
      for (int i = 0; i < sent_q.size() && start < 0; i++)
         if (sent_q[i].sof) start = i;
      if (start >= 0) begin
         for (int p = 0; (start + p) < sent_q.size() && !done; p++) begin
            len = p + 1;
            if (p > 0 && sent_q[start+p].idx != LOGS'(p)) erri = 1;
            if (sent_q[start+p].last) begin
               done = 1;
               errl = (p != N - 1);
            end else if (p == N - 1) begin
               done = 1;
               errl = 1;
            end
         end
      end
      if (done) exp_cnt++;
      check({tag, "_ready"}, 32'(frame_ready), 32'(done));
      check({tag, "_busy"}, 32'(busy), 32'(!done));
      check({tag, "_err_len"}, 32'(err_len), 32'(errl));
      check({tag, "_err_idx"}, 32'(err_idx), 32'(erri));
      check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_cnt));
      if (start >= 0) check({tag, "_blk_exp"}, 32'(blk_exp), 32'(sent_q[start].bexp));
      if (done) begin
         for (int p = 0; p < len; p++)
            read_check(p, {sent_q[start+p].im, sent_q[start+p].re}, $sformatf("%s_rd%0d", tag, p));
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ready"}, 32'(frame_ready), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_err_len"}, 32'(err_len), 32'd0);
      check({tag, "_err_idx"}, 32'(err_idx), 32'd0);
      check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
      check({tag, "_blk_exp"}, 32'(blk_exp), 32'd0);
      check({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
      check({tag, "_rd_data"}, 32'(rd_data), 32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      n_checks      = 0;
      n_pass        = 0;
      exp_cnt       = 0;
      prev_last     = 1;
      srstn         = 1'b0;
      aclken        = 1'b1;
      arm           = 1'b0;
      rd_en         = 1'b0;
      rd_addr       = '0;
      xk_bus.tvalid = 1'b0;
      xk_bus.tdata  = '0;
      xk_bus.tlast  = 1'b0;
      xk_bus.tuser  = '0;
      tick();
      tick();
      check_all_zero("reset");
      srstn = 1'b1;
      tick();

      // Ramp frame: re=k, im=-k, blk_exp=3.
      do_arm();
      check("t1_busy_armed", 32'(busy), 32'd1);
      make_frame(16, 15);
      for (int k = 0; k < 16; k++) begin
         f_re[k]  = OW'(k);
         f_im[k]  = OW'(-k);
         f_exp[k] = 8'd3;
      end
      send_range(0, 15);
      check("t1_blk_exp3", 32'(blk_exp), 32'd3);
      check_capture("t1");
      read_check(5, {11'h7FB, 11'd5}, "t1_addr5");
      tick();
      check("t1_rd_valid_low", 32'(rd_valid), 32'd0);

      // Arm in the middle of a frame: its tail is discarded, the next one captured.
      make_frame(16, 15);
      send_range(0, 6);
      do_arm();
      check("t2_ready_cleared", 32'(frame_ready), 32'd0);
      check("t2_busy", 32'(busy), 32'd1);
      send_range(7, 15);
      make_frame(16, 15);
      send_range(0, 15);
      check_capture("t2");

      // Short frame, with an ignored arm pulse during capture.
      do_arm();
      make_frame(10, 9);
      send_range(0, 4);
      pulse_arm();
      send_range(5, 9);
      check_capture("t3");

      // Missing tlast: capture stops at N beats, later beats must not overwrite.
      do_arm();
      check("t4_err_len_cleared", 32'(err_len), 32'd0);
      make_frame(22, 21);
      send_range(0, 21);
      check_capture("t4");

      // Index jump 3->5, sticky until the next arm.
      do_arm();
      make_frame(16, 15);
      for (int k = 4; k < 16; k++) f_idx[k] = LOGS'(k + 1);
      send_range(0, 15);
      check_capture("t5");
      make_frame(3, 2);
      send_range(0, 2);
      check("t5_err_idx_sticky", 32'(err_idx), 32'd1);
      do_arm();
      check("t5_err_idx_cleared", 32'(err_idx), 32'd0);
      check("t5_ready_cleared", 32'(frame_ready), 32'd0);

      // Clean capture, then reset in the middle of the next one.
      make_frame(16, 15);
      send_range(0, 15);
      check_capture("t6a");
      do_arm();
      make_frame(16, 15);
      send_range(0, 7);
      @(posedge clk);
      #3;
      srstn = 1'b0;
      #1;
      check_all_zero("t6_reset");
      tick();
      tick();
      srstn     = 1'b1;
      prev_last = 1;
      exp_cnt   = 0;
      sent_q.delete();
      make_frame(16, 15);
      send_range(0, 15);
      tick();
      check("t6_cnt_no_arm", 32'(frame_cnt), 32'd0);
      check("t6_ready_no_arm", 32'(frame_ready), 32'd0);
      check("t6_busy_no_arm", 32'(busy), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
